// File: rtl/dm_access_unit.sv
// dm_access_unit: one-outstanding load/store unit between a core and a DATA_W-wide data memory.
// Define DM_ACCESS_ALIGN_EXC_EN to flag misaligned half/word accesses instead of issuing them.
module dm_access_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_exc,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned LSB   = $clog2(LANES);

`ifdef DM_ACCESS_ALIGN_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("dm_access_unit: DATA_W must be 32 or 64");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
   typedef enum logic [2:0] {
      OP_LB  = 3'b000, OP_LBU = 3'b001, OP_LH = 3'b010, OP_LHU = 3'b011,
      OP_LW  = 3'b100, OP_SB  = 3'b101, OP_SH = 3'b110, OP_SW  = 3'b111
   } op_e;

   function automatic size_e op_size(input logic [2:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
         OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
         default:              op_size = SZ_W;
      endcase
   endfunction

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [LSB-1:0]      off_q, off_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LANES-1:0]    mem_be_q, mem_be_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_exc_q, resp_exc_d;

   // Request decode: lane offset aligned down to the access size, enables and replicated data.
   size_e               req_size;
   logic                req_store;
   logic                req_misaligned;
   logic [LSB-1:0]      req_lane;
   logic [LSB-1:0]      req_off;
   logic [LANES-1:0]    be_base;
   logic [LANES-1:0]    req_be;
   logic [DATA_W-1:0]   req_wrep;

   always_comb begin
      req_size  = op_size(req_op);
      req_store = req_op[2] & (req_op[1] | req_op[0]);
      req_lane  = req_addr[LSB-1:0];
      req_off   = req_lane;
      be_base   = LANES'(4'hF);
      req_wrep  = {(LANES/4){req_wdata[31:0]}};
      case (req_size)
         SZ_B: begin
            be_base  = LANES'(1'b1);
            req_wrep = {LANES{req_wdata[7:0]}};
         end
         SZ_H: begin
            req_off[0] = 1'b0;
            be_base    = LANES'(2'b11);
            req_wrep   = {(LANES/2){req_wdata[15:0]}};
         end
         default: req_off[1:0] = 2'b00;
      endcase
      req_misaligned = EXC_EN && ((req_size == SZ_H && req_lane[0]) ||
                                  (req_size == SZ_W && req_lane[1:0] != 2'b00));
      req_be = req_store ? (be_base << req_off) : '1;
      if (!req_store) req_wrep = '0;
   end

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] load_ext;

   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (op_q)
         OP_LB:   load_ext = DATA_W'($signed(shifted[7:0]));
         OP_LBU:  load_ext = DATA_W'(shifted[7:0]);
         OP_LH:   load_ext = DATA_W'($signed(shifted[15:0]));
         OP_LHU:  load_ext = DATA_W'(shifted[15:0]);
         OP_LW:   load_ext = DATA_W'($signed(shifted[31:0]));
         default: load_ext = '0;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      off_d        = off_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_exc_d   = resp_exc_q;
      req_ready    = 1'b0;
      mem_req      = 1'b0;
      resp_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d  = op_e'(req_op);
               off_d = req_off;
               if (req_misaligned) begin
                  state_d      = S_RESP;
                  resp_rdata_d = '0;
                  resp_exc_d   = 1'b1;
               end else begin
                  state_d     = S_REQ;
                  mem_we_d    = req_store;
                  mem_addr_d  = {req_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
                  mem_be_d    = req_be;
                  mem_wdata_d = req_wrep;
               end
            end
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d      = S_RESP;
               resp_rdata_d = load_ext;
               resp_exc_d   = 1'b0;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LB;
         off_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         resp_rdata_q <= '0;
         resp_exc_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         off_q        <= off_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_exc_q   <= resp_exc_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_exc   = EXC_EN & resp_exc_q;

   // Upper store-data and shifted read-data bits are legitimately ignored at DATA_W=64.
   logic unused_bits;
   assign unused_bits = ^{req_wdata, shifted};

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: a 32-bit and a 64-bit instance share stimulus,
// checked against an arithmetic reference model plus directed constant expectations.
`timescale 1ns/1ps
module tb_dm_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sel;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;

   logic        a_req_ready, a_resp_valid, a_resp_exc, a_mem_req, a_mem_we;
   logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_req_ready, b_resp_valid, b_resp_exc, b_mem_req, b_mem_we;
   logic [63:0] b_resp_rdata, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [7:0]  b_mem_be;

   dm_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_exc(a_resp_exc),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
      .mem_wdata(a_mem_wdata), .mem_gnt(mem_gnt & ~sel), .mem_rvalid(mem_rvalid & ~sel),
      .mem_rdata(mem_rdata[31:0])
   );

   dm_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_exc(b_resp_exc),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_gnt(mem_gnt & sel), .mem_rvalid(mem_rvalid & sel),
      .mem_rdata(mem_rdata)
   );

   logic        o_req_ready, o_resp_valid, o_resp_exc, o_mem_req, o_mem_we;
   logic [63:0] o_resp_rdata, o_mem_wdata;
   logic [31:0] o_mem_addr;
   logic [7:0]  o_mem_be;

   always_comb begin
      if (sel) begin
         o_req_ready = b_req_ready;  o_resp_valid = b_resp_valid; o_resp_exc = b_resp_exc;
         o_mem_req   = b_mem_req;    o_mem_we     = b_mem_we;     o_resp_rdata = b_resp_rdata;
         o_mem_wdata = b_mem_wdata;  o_mem_addr   = b_mem_addr;   o_mem_be = b_mem_be;
      end else begin
         o_req_ready = a_req_ready;  o_resp_valid = a_resp_valid; o_resp_exc = a_resp_exc;
         o_mem_req   = a_mem_req;    o_mem_we     = a_mem_we;     o_resp_rdata = {32'h0, a_resp_rdata};
         o_mem_wdata = {32'h0, a_mem_wdata}; o_mem_addr = a_mem_addr; o_mem_be = {4'h0, a_mem_be};
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: access size in bytes, byte masks and extension by plain arithmetic.
   function automatic int op_bytes(input logic [2:0] op);
      case (op)
         3'd0, 3'd1, 3'd5: return 1;
         3'd2, 3'd3, 3'd6: return 2;
         default:          return 4;
      endcase
   endfunction

   function automatic logic [63:0] byte_mask(input int nbytes);
      return (64'd1 << (8 * nbytes)) - 64'd1;
   endfunction

   logic [63:0] obs_rdata, obs_wdata;
   logic [31:0] obs_addr;
   logic [7:0]  obs_be;
   logic        obs_we, obs_exc;
   int          obs_lat, obs_req_cycles;

   task automatic run_access(input bit s, input logic [2:0] op, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [63:0] rd,
                             input int gnt_dly, input int rv_dly, input bit noise);
      int dw, lanes, size, off, lat, exp_lat, req_cycles;
      bit st, sgn, mis;
      logic [63:0] m, v, exp_rd, exp_wd, be_full;
      logic [7:0]  exp_be;
      logic [31:0] exp_addr;

      dw    = s ? 64 : 32;
      lanes = dw / 8;
      size  = op_bytes(op);
      st    = (op >= 3'd5);
      sgn   = (op == 3'd0 || op == 3'd2 || op == 3'd4);
      off   = int'(addr % lanes);
      off   = off - (off % size);
`ifdef DM_ACCESS_ALIGN_EXC_EN
      mis   = (addr % size) != 0;
`else
      mis   = 1'b0;
`endif
      m = byte_mask(size);
      if (st || mis) exp_rd = 64'h0;
      else begin
         v = ((rd & byte_mask(lanes)) >> (8 * off)) & m;
         if (sgn && v[8 * size - 1]) v = v | ~m;
         exp_rd = v & byte_mask(lanes);
      end
      be_full  = st ? (byte_mask(size) >> (8 * size - size)) << off : (64'd1 << lanes) - 64'd1;
      exp_be   = be_full[7:0];
      exp_wd   = 64'h0;
      for (int i = 0; i < lanes / size; i++) exp_wd = exp_wd | ((wd & m) << (8 * size * i));
      exp_addr = addr & ~32'(lanes - 1);
      exp_lat  = mis ? 1 : 3 + gnt_dly + rv_dly;

      if (sel != s) begin
         sel = s;
         @(negedge clk);
      end
      check("idle_ready", o_req_ready, 1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};
      lat = 1;
      req_cycles = 0;
      if (!mis) begin
         for (int g = 0; g <= gnt_dly; g++) begin
            check("mem_req", o_mem_req, 1);
            check("ready_busy_req", o_req_ready, 0);
            check("mem_addr", o_mem_addr, exp_addr);
            check("mem_be", o_mem_be, exp_be);
            check("mem_we", o_mem_we, st);
            if (st) check("mem_wdata", o_mem_wdata, exp_wd);
            if (g == 0) begin
               obs_addr = o_mem_addr; obs_be = o_mem_be; obs_we = o_mem_we; obs_wdata = o_mem_wdata;
            end
            req_cycles += int'(o_mem_req);
            mem_gnt    = (g == gnt_dly);
            mem_rvalid = noise && (g != gnt_dly) && ($urandom_range(0, 1) == 1);
            mem_rdata  = {$urandom, $urandom};
            @(negedge clk);
            lat++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
         end
         for (int r = 0; r <= rv_dly; r++) begin
            check("wait_no_req", o_mem_req, 0);
            check("ready_busy_wait", o_req_ready, 0);
            check("resp_early", o_resp_valid, 0);
            req_cycles += int'(o_mem_req);
            mem_rvalid = (r == rv_dly);
            mem_rdata  = (r == rv_dly) ? rd : {$urandom, $urandom};
            @(negedge clk);
            lat++;
            mem_rvalid = 1'b0;
         end
      end
      req_cycles += int'(o_mem_req);
      check("resp_valid", o_resp_valid, 1);
      check("latency", lat, exp_lat);
      check("resp_rdata", o_resp_rdata, exp_rd);
      check("resp_exc", o_resp_exc, mis);
      check("ready_busy_resp", o_req_ready, 0);
      obs_rdata = o_resp_rdata; obs_exc = o_resp_exc; obs_lat = lat; obs_req_cycles = req_cycles;
      @(negedge clk);
      check("resp_pulse", o_resp_valid, 0);
      check("ready_again", o_req_ready, 1);
      check("rdata_hold", o_resp_rdata, exp_rd);
      check("exc_hold", o_resp_exc, mis);
   endtask

   task automatic check_reset_state(input string tag);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check({tag, "_ready"}, o_req_ready, 1);
         check({tag, "_resp_valid"}, o_resp_valid, 0);
         check({tag, "_resp_rdata"}, o_resp_rdata, 0);
         check({tag, "_resp_exc"}, o_resp_exc, 0);
         check({tag, "_mem_req"}, o_mem_req, 0);
         check({tag, "_mem_we"}, o_mem_we, 0);
         check({tag, "_mem_addr"}, o_mem_addr, 0);
         check({tag, "_mem_be"}, o_mem_be, 0);
         check({tag, "_mem_wdata"}, o_mem_wdata, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      @(negedge clk);
      reset = 1'b0;
      sel = 1'b0;
      @(negedge clk);

      // (a) LB from lane 1
      run_access(0, 3'd0, 32'h1, 64'h0, 64'h8899AABB, 0, 0, 0);
      check("a_rdata", obs_rdata, 64'hFFFFFFAA);
      check("a_be", obs_be, 64'hF);
      check("a_addr", obs_addr, 64'h0);
      check("a_lat", obs_lat, 3);
      // (b) LBU lane 3, LH upper half
      run_access(0, 3'd1, 32'h3, 64'h0, 64'h8899AABB, 0, 0, 0);
      check("b_lbu", obs_rdata, 64'h88);
      run_access(0, 3'd2, 32'h2, 64'h0, 64'h8899AABB, 0, 0, 0);
      check("b_lh", obs_rdata, 64'hFFFF8899);
      // (c) SH upper half of word 4
      run_access(0, 3'd6, 32'h6, 64'h1234, 64'hDEADBEEF, 0, 0, 0);
      check("c_addr", obs_addr, 64'h4);
      check("c_be", obs_be, 64'hC);
      check("c_wdata", obs_wdata, 64'h12341234);
      check("c_we", obs_we, 1);
      check("c_rdata", obs_rdata, 64'h0);
      // (d) delayed grant and read data
      run_access(0, 3'd4, 32'h8, 64'h0, 64'h13572468, 3, 1, 0);
      check("d_req_cycles", obs_req_cycles, 4);
      check("d_lat", obs_lat, 7);
      check("d_rdata", obs_rdata, 64'h13572468);
      // (e) misaligned word load
      run_access(0, 3'd4, 32'h2, 64'h0, 64'hCAFEF00D, 0, 0, 0);
`ifdef DM_ACCESS_ALIGN_EXC_EN
      check("e_lat", obs_lat, 1);
      check("e_exc", obs_exc, 1);
      check("e_no_req", obs_req_cycles, 0);
      check("e_rdata", obs_rdata, 64'h0);
`else
      check("e_addr", obs_addr, 64'h0);
      check("e_exc", obs_exc, 0);
      check("e_rdata", obs_rdata, 64'hCAFEF00D);
`endif
      // (f) 64-bit word load from upper half, then reset while waiting
      run_access(1, 3'd4, 32'h4, 64'h0, 64'h80000001_00000000, 0, 0, 0);
      check("f_rdata", obs_rdata, 64'hFFFFFFFF80000001);
      req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h14;
      @(negedge clk);
      req_valid = 1'b0;
      check("f_req", o_mem_req, 1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("f_wait", o_mem_req, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_state("f_rst");
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'h11112222_33334444;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("f_no_resp", o_resp_valid, 0);
         check("f_idle_ready", o_req_ready, 1);
         @(negedge clk);
      end

      // Randomized accesses on both widths with random wait states and stray rvalid pulses
      for (int n = 0; n < 300; n++) begin
         run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data-bus width and be legal only at 32 or 64; LANES = DATA_W/8 and LSB = log2(LANES).
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  req_valid  in  1  access request
  req_ready  out  1  block can accept a request
  req_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
  req_addr  in  ADDR_W  byte address
  req_wdata  in  DATA_W  store data, right-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  DATA_W  extended load result; 0 for stores
  resp_exc  out  1  misaligned access, qualified by resp_valid
  mem_req  out  1  memory request
  mem_we  out  1  1 = write
  mem_addr  out  ADDR_W  req_addr with low LSB bits zeroed
  mem_be  out  LANES  byte enables
  mem_wdata  out  DATA_W  lane-replicated store data
  mem_gnt  in  1  memory accepted mem_req
  mem_rvalid  in  1  read data valid or write acknowledged
  mem_rdata  in  DATA_W  read data

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT and RESP, and SHALL hold one access in flight at most.
REQ-006 IDLE: req_ready=1; on req_valid, capture op, addr and wdata; go to RESP with exception if misaligned, else to REQ.
REQ-007 REQ: mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata held stable until mem_gnt; on mem_gnt go to WAIT.
REQ-008 WAIT: mem_req=0; on mem_rvalid, register the extracted result and go to RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-009 RESP: resp_valid=1 for exactly one cycle, then return to IDLE; req_ready=0 in REQ, WAIT and RESP.
REQ-010 Minimum latency with zero wait states SHALL be: accept T, mem_req T+1, gnt T+1, rvalid T+2, resp_valid T+3.
REQ-011 The lane select SHALL be addr[LSB-1:0]; byte ops use lane addr[LSB-1:0], half ops use half-lane addr[LSB-1:1], word ops use word-lane addr[LSB-1:2] (always 0 when DATA_W=32).
REQ-012 Loads: LB/LH/LW SHALL sign-extend the selected field to DATA_W; LBU/LHU SHALL zero-extend it; all mem_be bits = 1.
REQ-013 Stores: mem_be SHALL cover only the selected bytes; mem_wdata SHALL replicate the low 8/16/32 bits of wdata across all lanes.
REQ-014 A misaligned access SHALL be a half access with addr[0]≠0 or a word access with addr[1:0]≠0.
REQ-015 A misaligned access SHALL never assert mem_req; resp_rdata=0 and resp_exc=1.
REQ-016 resp_rdata and resp_exc SHALL hold their values until the next RESP.

Reset
REQ-017 reset SHALL force IDLE, regardless of state.
REQ-018 reset SHALL clear req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0 and mem_wdata=0.
REQ-019 reset during REQ or WAIT SHALL abandon the access with no response; a late mem_rvalid SHALL be ignored.

Configuration
REQ-020 With macro DM_ACCESS_ALIGN_EXC_EN defined, REQ-014/015 SHALL apply.
REQ-021 Without DM_ACCESS_ALIGN_EXC_EN, resp_exc SHALL be tied 0 and misaligned low bits SHALL be silently dropped; every access goes to memory.

Verification
REQ-022 The bench SHALL cover each of the following directed scenarios:
  (a) DATA_W=32, LB addr 0x1, mem_rdata 0x8899AABB -> resp_rdata 0xFFFFFFAA, mem_be 1111, mem_addr 0x0.
  (b) LBU addr 0x3 and LH addr 0x2, same data -> 0x00000088 and 0xFFFF8899.
  (c) SH addr 0x6, wdata 0x00001234 -> mem_addr 0x4, mem_be 1100, mem_wdata 0x12341234, mem_we 1, resp_rdata 0.
  (d) mem_gnt delayed 3 cycles, rvalid 2 cycles later, LW addr 0x8 -> mem_req stable for 4 cycles, resp_valid 7 cycles after accept, req_ready low throughout.
  (e) With the macro, LW addr 0x2 -> resp_valid at T+1 with resp_exc 1 and no mem_req; without the macro -> mem_addr 0x0, resp_exc 0.
  (f) DATA_W=64, LW addr 0x4, mem_rdata 0x80000001_00000000 -> resp_rdata 0xFFFFFFFF80000001; reset in WAIT followed by rvalid -> no resp_valid.
